net_packet_rx: RTL and testbench
================================

// Module: net_packet_rx
// PURPOSE
//  Core-side receiver for the boot/control network: consumes one net_packet_s per cycle from the
//  host/bench injector and applies it to core state (imem, regfile, barrier mask, PC/start).
//  Register writes are buffered until the core's regfile port is free. PC-start is held until every
//  earlier REG write has been committed. Sits between the network input and the core pipeline.
// PARAMETERS
//  CORE_ID_P        10'd1  packet ID this receiver accepts; all other IDs are ignored
//  IMEM_ADDR_W_P    10     imem address width (net_addr bits used)
//  REG_FIFO_DEPTH_P 4      pending REG-write entries; power of 2, >=2
// PORTS
//  clk               in   1                  clock
//  n_reset           in   1                  reset, synchronous, active-low
//  net_packet_flat_i in   $bits(net_packet_s) incoming packet, valid every cycle (NULL = idle)
//  imem_wen_o        out  1                  instruction write strobe
//  imem_addr_o       out  IMEM_ADDR_W_P      instruction address
//  imem_data_o       out  instr_length_gp    instruction word
//  rf_wen_o          out  1                  register write strobe
//  rf_addr_o         out  rs_imm_size_gp     register index
//  rf_data_o         out  32                 register data
//  rf_ready_i        in   1                  core regfile write port free this cycle
//  bar_mask_o        out  mask_length_gp     barrier mask register
//  pc_o              out  IMEM_ADDR_W_P      start PC, valid with pc_load_o
//  pc_load_o         out  1                  one-cycle PC load pulse
//  run_o             out  1                  core may fetch/execute
//  overflow_o        out  1                  sticky: REG packet dropped, FIFO full
//  instr_cnt_o/reg_cnt_o/drop_cnt_o out 16   statistics (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, state IDLE, pending PC cleared. Reset mid-operation flushes.
//  - Accept only ID==CORE_ID_P. Ignore other IDs, NULL, and any op not in {INSTR,REG,BAR,PC}.
//  - INSTR: next cycle imem_wen_o=1, addr=net_addr[IMEM_ADDR_W_P-1:0], data=net_data[instr_length_gp-1:0].
//    Latency 1 with no backpressure. Accepted in every state.
//  - REG: push {net_addr[rs_imm_size_gp-1:0], net_data} into FIFO.
//    Pop when non-empty && rf_ready_i; rf_wen_o/addr/data are registered from the head, 1 cycle after pop.
//    Min latency packet->rf_wen_o = 2 cycles.
//  - FIFO full + push + no pop: drop the packet and set overflow_o (cleared only by reset).
//  - FIFO full + push + pop in the same cycle: both proceed, no drop.
//  - BAR: bar_mask_o <= net_data[mask_length_gp-1:0] next cycle; net_addr ignored.
//  - PC: target = net_addr[IMEM_ADDR_W_P-1:0]; net_data ignored. Latch target and go to PEND.
//  - FSM:
//    IDLE  run_o=0; PC -> PEND.
//    PEND  run_o=0; when FIFO empty && no rf write in flight -> pc_load_o=1, pc_o=target, go RUN.
//          A second PC while in PEND overwrites the target.
//    RUN   run_o=1; PC -> PEND (run_o drops the next cycle, restart).
//  - pc_load_o is a single-cycle pulse; run_o rises in the same cycle as pc_load_o.
// CONFIGURATION
//  NET_RX_STATS_EN defined:
//    instr_cnt_o, reg_cnt_o: accepted INSTR/REG packets. drop_cnt_o: dropped REG packets.
//    All 16-bit, saturating at 16'hFFFF, reset to 0.
//  NET_RX_STATS_EN undefined: the three ports are tied to 0 and no counter flops are built.
// STRUCTURE
//  definitions package: net_rx_state_e {IDLE,PEND,RUN}; reg_wr_s {addr,data}.
//    net_packet_s and net_op values already live there.
//  Sub-module net_rx_reg_fifo: sync FIFO of reg_wr_s with push/pop/full/empty.
//    Pointers are log2(depth)+1 bits wide.
// TESTING
//  1 INSTR id=1 addr=3 data=16'hA5C3 -> next cycle imem_wen_o=1, imem_addr_o=3, imem_data_o=16'hA5C3.
//  2 REG addr=5 data=32'hDEADBEEF with rf_ready_i=0 for 3 cycles, then 1
//    -> rf_wen_o=1, rf_addr_o=5, rf_data_o=32'hDEADBEEF one cycle after ready rises.
//  3 REG x5 back-to-back, rf_ready_i=0, depth 4 -> 5th dropped, overflow_o=1, drop_cnt_o=1 (stats on);
//    raise ready -> exactly 4 writes, in order.
//  4 REG x2 then PC addr=0 data=5, rf_ready_i=1 -> pc_load_o only after 2nd rf_wen_o,
//    pc_o=0, run_o=1 from that cycle.
//  5 BAR data=32'h2 -> bar_mask_o=2. Packet with ID=2 or op NULL -> no output strobes.
//  6 Reset asserted in PEND with FIFO non-empty -> all outputs 0, no later rf_wen_o or pc_load_o.

Source files
------------

// File: rtl/net_packet_rx_pkg.sv
// Shared network/core definitions for the boot/control packet receiver.
// Packet layout, opcode values, receiver state and the pending register-write record live here.
package net_packet_rx_pkg;

  localparam int instr_length_gp   = 16;
  localparam int rs_imm_size_gp    = 6;
  localparam int mask_length_gp    = 3;
  localparam int net_id_width_gp   = 10;
  localparam int net_addr_width_gp = 10;
  localparam int net_data_width_gp = 32;

  typedef enum logic [2:0] {
    NET_NULL  = 3'd0,
    NET_INSTR = 3'd1,
    NET_REG   = 3'd2,
    NET_PC    = 3'd3,
    NET_BAR   = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [net_id_width_gp-1:0]   id;
    net_op_e                      net_op;
    logic [net_data_width_gp-1:0] net_data;
    logic [net_addr_width_gp-1:0] net_addr;
  } net_packet_s;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    RUN
  } net_rx_state_e;

  typedef struct packed {
    logic [rs_imm_size_gp-1:0] addr;
    logic [31:0]               data;
  } reg_wr_s;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/net_packet_rx_reg_fifo.sv
// Synchronous FIFO of pending register writes for the packet receiver.
// Caller must not push when full unless it pops in the same cycle, and never pops when empty.
module net_rx_reg_fifo
  import net_packet_rx_pkg::*;
#(
  parameter int DEPTH_P = 4
) (
  input  logic    clk,
  input  logic    n_reset,
  input  logic    push,
  input  reg_wr_s push_data,
  input  logic    pop,
  output reg_wr_s head,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(DEPTH_P) + 1;

  reg_wr_s          mem [DEPTH_P];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
  assign head  = mem[rd_ptr[PTR_W-2:0]];

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-2:0]] <= push_data;
  end

endmodule

// File: rtl/net_packet_rx.sv
// Core-side boot/control network receiver: applies INSTR, REG, BAR and PC packets to core state.
// Define NET_RX_STATS_EN to build the saturating instr/reg/drop statistics counters.
module net_packet_rx
  import net_packet_rx_pkg::*;
#(
  parameter logic [net_id_width_gp-1:0] CORE_ID_P        = 10'd1,
  parameter int                         IMEM_ADDR_W_P    = 10,
  parameter int                         REG_FIFO_DEPTH_P = 4
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic [$bits(net_packet_s)-1:0] net_packet_flat_i,
  output logic                       imem_wen_o,
  output logic [IMEM_ADDR_W_P-1:0]   imem_addr_o,
  output logic [instr_length_gp-1:0] imem_data_o,
  output logic                       rf_wen_o,
  output logic [rs_imm_size_gp-1:0]  rf_addr_o,
  output logic [31:0]                rf_data_o,
  input  logic                       rf_ready_i,
  output logic [mask_length_gp-1:0]  bar_mask_o,
  output logic [IMEM_ADDR_W_P-1:0]   pc_o,
  output logic                       pc_load_o,
  output logic                       run_o,
  output logic                       overflow_o,
  output logic [15:0]                instr_cnt_o,
  output logic [15:0]                reg_cnt_o,
  output logic [15:0]                drop_cnt_o
);

  net_packet_s   pkt;
  logic          accept;
  logic          is_instr;
  logic          is_reg;
  logic          is_bar;
  logic          is_pc;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          reg_drop;
  reg_wr_s       fifo_in;
  reg_wr_s       fifo_head;
  net_rx_state_e state;
  logic [IMEM_ADDR_W_P-1:0] pc_target;

  assign pkt      = net_packet_s'(net_packet_flat_i);
  assign accept   = (pkt.id == CORE_ID_P);
  assign is_instr = accept && (pkt.net_op == NET_INSTR);
  assign is_reg   = accept && (pkt.net_op == NET_REG);
  assign is_bar   = accept && (pkt.net_op == NET_BAR);
  assign is_pc    = accept && (pkt.net_op == NET_PC);

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign fifo_pop  = !fifo_empty && rf_ready_i;
  assign fifo_push = is_reg && (!fifo_full || fifo_pop);
  assign reg_drop  = is_reg && fifo_full && !fifo_pop;
  assign fifo_in   = '{addr: pkt.net_addr[rs_imm_size_gp-1:0], data: pkt.net_data};

  net_rx_reg_fifo #(
    .DEPTH_P (REG_FIFO_DEPTH_P)
  ) u_reg_fifo (
    .clk       (clk),
    .n_reset   (n_reset),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      imem_wen_o  <= 1'b0;
      imem_addr_o <= '0;
      imem_data_o <= '0;
      bar_mask_o  <= '0;
      overflow_o  <= 1'b0;
    end else begin
      imem_wen_o <= is_instr;
      if (is_instr) begin
        imem_addr_o <= pkt.net_addr[IMEM_ADDR_W_P-1:0];
        imem_data_o <= pkt.net_data[instr_length_gp-1:0];
      end
      if (is_bar)   bar_mask_o <= pkt.net_data[mask_length_gp-1:0];
      if (reg_drop) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rf_wen_o  <= 1'b0;
      rf_addr_o <= '0;
      rf_data_o <= '0;
    end else begin
      rf_wen_o <= fifo_pop;
      if (fifo_pop) begin
        rf_addr_o <= fifo_head.addr;
        rf_data_o <= fifo_head.data;
      end
    end
  end

  // PC start waits until the FIFO is drained and the last popped write has reached the regfile.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state     <= IDLE;
      pc_target <= '0;
      pc_o      <= '0;
      pc_load_o <= 1'b0;
      run_o     <= 1'b0;
    end else begin
      pc_load_o <= 1'b0;
      case (state)
        IDLE: begin
          if (is_pc) begin
            pc_target <= pkt.net_addr[IMEM_ADDR_W_P-1:0];
            state     <= PEND;
          end
        end
        PEND: begin
          if (is_pc) begin
            pc_target <= pkt.net_addr[IMEM_ADDR_W_P-1:0];
          end else if (fifo_empty && !rf_wen_o) begin
            pc_load_o <= 1'b1;
            pc_o      <= pc_target;
            run_o     <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (is_pc) begin
            pc_target <= pkt.net_addr[IMEM_ADDR_W_P-1:0];
            run_o     <= 1'b0;
            state     <= PEND;
          end
        end
        default: begin
          run_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef NET_RX_STATS_EN
  logic [15:0] instr_cnt;
  logic [15:0] reg_cnt;
  logic [15:0] drop_cnt;

  // reg_cnt counts REG packets that made it into the FIFO; dropped ones go to drop_cnt.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      instr_cnt <= '0;
      reg_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      if (is_instr)  instr_cnt <= sat_inc16(instr_cnt);
      if (fifo_push) reg_cnt   <= sat_inc16(reg_cnt);
      if (reg_drop)  drop_cnt  <= sat_inc16(drop_cnt);
    end
  end

  assign instr_cnt_o = instr_cnt;
  assign reg_cnt_o   = reg_cnt;
  assign drop_cnt_o  = drop_cnt;
`else
  assign instr_cnt_o = '0;
  assign reg_cnt_o   = '0;
  assign drop_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_net_packet_rx.sv
// Scoreboard bench for net_packet_rx: directed scenarios followed by randomized traffic.
// Expected results come from a queue-based model of the receiver rules.
module tb_net_packet_rx;
  import net_packet_rx_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [$bits(net_packet_s)-1:0] net_packet_flat_i = '0;
  logic        rf_ready_i = 1'b0;
  logic        imem_wen_o;
  logic [9:0]  imem_addr_o;
  logic [15:0] imem_data_o;
  logic        rf_wen_o;
  logic [5:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic [2:0]  bar_mask_o;
  logic [9:0]  pc_o;
  logic        pc_load_o;
  logic        run_o;
  logic        overflow_o;
  logic [15:0] instr_cnt_o;
  logic [15:0] reg_cnt_o;
  logic [15:0] drop_cnt_o;

  net_packet_rx #(
    .CORE_ID_P        (10'd1),
    .IMEM_ADDR_W_P    (10),
    .REG_FIFO_DEPTH_P (DEPTH)
  ) dut (
    .clk               (clk),
    .n_reset           (n_reset),
    .net_packet_flat_i (net_packet_flat_i),
    .imem_wen_o        (imem_wen_o),
    .imem_addr_o       (imem_addr_o),
    .imem_data_o       (imem_data_o),
    .rf_wen_o          (rf_wen_o),
    .rf_addr_o         (rf_addr_o),
    .rf_data_o         (rf_data_o),
    .rf_ready_i        (rf_ready_i),
    .bar_mask_o        (bar_mask_o),
    .pc_o              (pc_o),
    .pc_load_o         (pc_load_o),
    .run_o             (run_o),
    .overflow_o        (overflow_o),
    .instr_cnt_o       (instr_cnt_o),
    .reg_cnt_o         (reg_cnt_o),
    .drop_cnt_o        (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    int          cyc;
    logic        run;
    logic        pc_load;
    logic        ovf;
    logic [9:0]  pc;
    logic [2:0]  bar;
    logic [15:0] ic;
    logic [15:0] rc;
    logic [15:0] dc;
  } st_exp_t;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } pend_t;

  wr_exp_t imem_q[$];
  wr_exp_t rf_q[$];
  st_exp_t st_q[$];

  pend_t       m_fifo[$];
  bit          m_pend = 0;
  bit          m_run = 0;
  bit          m_wen_now = 0;
  bit          m_ovf = 0;
  logic [9:0]  m_target = '0;
  logic [9:0]  m_pc = '0;
  logic [2:0]  m_bar = '0;
  logic [15:0] m_ic = '0;
  logic [15:0] m_rc = '0;
  logic [15:0] m_dc = '0;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model by one clock.
  task automatic applyStimulus(input logic rst_n, input logic [9:0] id, input logic [2:0] op,
                               input logic [31:0] data, input logic [9:0] addr, input logic ready);
    st_exp_t s;
    pend_t   p;
    bit      acc;
    bit      empty_pre;
    bit      pc_go;
    bit      popped;
    @(negedge clk);
    n_reset           = rst_n;
    net_packet_flat_i = {id, op, data, addr};
    rf_ready_i        = ready;
    pc_go = 0;
    if (!rst_n) begin
      m_fifo.delete();
      m_pend = 0; m_run = 0; m_wen_now = 0; m_ovf = 0;
      m_target = '0; m_pc = '0; m_bar = '0;
      m_ic = '0; m_rc = '0; m_dc = '0;
    end else begin
      acc       = (id == 10'd1);
      empty_pre = (m_fifo.size() == 0);
      if (acc && op == 3'd1) begin
        imem_q.push_back('{cyc + 1, {22'd0, addr}, {16'd0, data[15:0]}});
`ifdef NET_RX_STATS_EN
        if (m_ic != 16'hFFFF) m_ic++;
`endif
      end
      if (acc && op == 3'd4) m_bar = data[2:0];
      if (acc && op == 3'd3) begin
        m_target = addr;
        m_pend   = 1;
        m_run    = 0;
      end else if (m_pend && empty_pre && !m_wen_now) begin
        pc_go  = 1;
        m_pend = 0;
        m_run  = 1;
        m_pc   = m_target;
      end
      popped = !empty_pre && ready;
      if (popped) begin
        p = m_fifo.pop_front();
        rf_q.push_back('{cyc + 1, {26'd0, p.a}, p.d});
      end
      if (acc && op == 3'd2) begin
        if (m_fifo.size() < DEPTH) begin
          m_fifo.push_back('{addr[5:0], data});
`ifdef NET_RX_STATS_EN
          if (m_rc != 16'hFFFF) m_rc++;
`endif
        end else begin
          m_ovf = 1;
`ifdef NET_RX_STATS_EN
          if (m_dc != 16'hFFFF) m_dc++;
`endif
        end
      end
      m_wen_now = popped;
    end
    s = '{cyc + 1, m_run, pc_go, m_ovf, m_pc, m_bar, m_ic, m_rc, m_dc};
    st_q.push_back(s);
  endtask

  task automatic idle(input int n, input logic ready);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 10'd0, 3'd0, 32'd0, 10'd0, ready);
  endtask

  // Monitor: compares registered outputs each cycle against the scoreboard queues.
  initial begin
    st_exp_t s;
    wr_exp_t w;
    bit      exp_w;
    forever begin
      @(negedge clk);
      if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
        s = st_q.pop_front();
        checkOutput("run_o", {31'd0, run_o}, {31'd0, s.run});
        checkOutput("pc_load_o", {31'd0, pc_load_o}, {31'd0, s.pc_load});
        if (s.pc_load) checkOutput("pc_o", {22'd0, pc_o}, {22'd0, s.pc});
        checkOutput("overflow_o", {31'd0, overflow_o}, {31'd0, s.ovf});
        checkOutput("bar_mask_o", {29'd0, bar_mask_o}, {29'd0, s.bar});
        checkOutput("instr_cnt_o", {16'd0, instr_cnt_o}, {16'd0, s.ic});
        checkOutput("reg_cnt_o", {16'd0, reg_cnt_o}, {16'd0, s.rc});
        checkOutput("drop_cnt_o", {16'd0, drop_cnt_o}, {16'd0, s.dc});
      end
      exp_w = (imem_q.size() > 0 && imem_q[0].cyc == cyc);
      checkOutput("imem_wen_o", {31'd0, imem_wen_o}, {31'd0, exp_w});
      if (exp_w) begin
        w = imem_q.pop_front();
        checkOutput("imem_addr_o", {22'd0, imem_addr_o}, w.addr);
        checkOutput("imem_data_o", {16'd0, imem_data_o}, w.data);
      end
      exp_w = (rf_q.size() > 0 && rf_q[0].cyc == cyc);
      checkOutput("rf_wen_o", {31'd0, rf_wen_o}, {31'd0, exp_w});
      if (exp_w) begin
        w = rf_q.pop_front();
        checkOutput("rf_addr_o", {26'd0, rf_addr_o}, w.addr);
        checkOutput("rf_data_o", rf_data_o, w.data);
      end
    end
  end

  initial begin
    int pct;
    logic [9:0] rid;
    logic [2:0] rop;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 10'd0, 3'd0, 32'd0, 10'd0, 1'b0);
    idle(2, 1'b0);

    applyStimulus(1'b1, 10'd1, 3'd1, 32'h0000A5C3, 10'd3, 1'b0);
    idle(2, 1'b0);

    applyStimulus(1'b1, 10'd1, 3'd2, 32'hDEADBEEF, 10'd5, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);

    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 10'd1, 3'd2, 32'h1000_0000 + i, 10'(i + 8), 1'b0);
    idle(2, 1'b0);
    idle(7, 1'b1);

    applyStimulus(1'b1, 10'd1, 3'd2, 32'hCAFE0001, 10'd1, 1'b1);
    applyStimulus(1'b1, 10'd1, 3'd2, 32'hCAFE0002, 10'd2, 1'b1);
    applyStimulus(1'b1, 10'd1, 3'd3, 32'd5, 10'd0, 1'b1);
    idle(6, 1'b1);

    applyStimulus(1'b1, 10'd1, 3'd4, 32'h2, 10'h3FF, 1'b1);
    applyStimulus(1'b1, 10'd2, 3'd1, 32'h1234, 10'd7, 1'b1);
    applyStimulus(1'b1, 10'd2, 3'd2, 32'h5678, 10'd7, 1'b1);
    applyStimulus(1'b1, 10'd1, 3'd0, 32'h9ABC, 10'd7, 1'b1);
    applyStimulus(1'b1, 10'd1, 3'd7, 32'hDEF0, 10'd7, 1'b1);
    idle(2, 1'b1);

    applyStimulus(1'b1, 10'd1, 3'd2, 32'h0BAD0001, 10'd9, 1'b0);
    applyStimulus(1'b1, 10'd1, 3'd2, 32'h0BAD0002, 10'd10, 1'b0);
    applyStimulus(1'b1, 10'd1, 3'd3, 32'd0, 10'd44, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b0, 10'd0, 3'd0, 32'd0, 10'd0, 1'b1);
    applyStimulus(1'b0, 10'd0, 3'd0, 32'd0, 10'd0, 1'b1);
    idle(5, 1'b1);

    for (int i = 0; i < 800; i++) begin
      pct = ((i / 100) % 2 == 1) ? 85 : 25;
      rid = ($urandom_range(0, 4) == 0) ? 10'd2 : 10'd1;
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) rop = 3'd2;
      applyStimulus(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, rid, rop,
                    $urandom, 10'($urandom), ($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0);
    end

    idle(12, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("drain_imem_q", imem_q.size(), 32'd0);
    checkOutput("drain_rf_q", rf_q.size(), 32'd0);
    checkOutput("drain_st_q", st_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
